shr2_seq: RTL and testbench

SHR2_SEQ -- requirements
Module: shr2_seq

---
 rtl/shr2_pkg.sv | 13 +
 rtl/shr2_step.sv | 17 +
 rtl/shr2_seq.sv | 73 +++++++
 tb/tb_shr2_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/shr2_pkg.sv
// Shared definitions for the shr2_seq 2-bit right-shift sequencer.
// Holds the state encoding and the default register width.
package shr2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shr2_step.sv
// Combinational single step: shift vec right by two and insert inadd at the MSBs.
// The pair of bits that falls off the bottom is returned on res.
module shr2_step
  import shr2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [1:0]       inadd,
  output logic [WIDTH-1:0] shifted,
  output logic [1:0]       res
);

  assign shifted = {inadd, vec[WIDTH-1:2]};
  assign res     = vec[1:0];

endmodule

// File: rtl/shr2_seq.sv
// Sequenced 2-bit right shifter: load an operand, then run STEPS shift steps.
// Define SHR2_SEQ_AUTO_EN to step on every RUN cycle instead of only when shift=1.
module shr2_seq
  import shr2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEPS = WIDTH / 2,
  localparam int CW   = $clog2(STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic [1:0]       inadd,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       res,
  output logic [CW-1:0]    cnt,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             step_req;
  logic [WIDTH-1:0] step_vec;
  logic [1:0]       step_res;
  logic [CW-1:0]    cnt_next;

`ifdef SHR2_SEQ_AUTO_EN
  // shift is still referenced so the port list stays identical in both builds
  assign step_req = 1'b1 | shift;
`else
  assign step_req = shift;
`endif

  assign cnt_next = cnt + 1'b1;

  shr2_step #(.WIDTH(WIDTH)) u_step (
    .vec     (dout),
    .inadd   (inadd),
    .shifted (step_vec),
    .res     (step_res)
  );

  // Priority: reset, then load (from any state), then a step while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dout  <= '0;
      res   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      state <= RUN;
      dout  <= din;
      res   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == RUN && step_req) begin
      dout <= step_vec;
      res  <= step_res;
      cnt  <= cnt_next;
      if (cnt_next == CW'(STEPS)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shr2_seq.sv
// Self-checking bench for shr2_seq: directed scenarios plus random traffic
// compared against an arithmetic reference model.
module tb_shr2_seq;

  localparam int WIDTH = 8;
  localparam int STEPS = 4;
  localparam int CW    = $clog2(STEPS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             shift;
  logic [1:0]       inadd;
  logic [WIDTH-1:0] dout;
  logic [1:0]       res;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = running, 2 = finished
  int m_dout;
  int m_res;
  int m_cnt;
  int m_phase;

  shr2_seq #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .shift (shift),
    .inadd (inadd),
    .dout  (dout),
    .res   (res),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    bit do_step;
`ifdef SHR2_SEQ_AUTO_EN
    do_step = 1'b1;
`else
    do_step = shift;
`endif
    if (rst) begin
      m_dout = 0; m_res = 0; m_cnt = 0; m_phase = 0;
    end else if (load) begin
      m_dout = int'(din); m_res = 0; m_cnt = 0; m_phase = 1;
    end else if (m_phase == 1 && do_step) begin
      m_res  = m_dout % 4;
      m_dout = m_dout / 4 + int'(inadd) * (2 ** (WIDTH - 2));
      m_cnt  = m_cnt + 1;
      if (m_cnt == STEPS) m_phase = 2;
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check_val({tag, ".res"},  32'(res),  32'(m_res));
    check_val({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    check_val({tag, ".busy"}, 32'(busy), 32'(m_phase == 1));
    check_val({tag, ".done"}, 32'(done), 32'(m_phase == 2));
  endtask

  // Drive inputs shortly after an edge, take the next edge, then sample 1ns later.
  task automatic apply_stimulus(input string tag, input logic r, input logic l,
                                input logic [WIDTH-1:0] d, input logic s, input logic [1:0] a);
    rst = r; load = l; din = d; shift = s; inadd = a;
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_seq [4];
    logic [1:0]       exp_res [4];
    exp_seq = '{8'h6D, 8'h5B, 8'h56, 8'h55};
    exp_res = '{2'b00, 2'b01, 2'b11, 2'b10};
    m_dout = 0; m_res = 0; m_cnt = 0; m_phase = 0;
    rst = 1'b1; load = 1'b0; din = '0; shift = 1'b0; inadd = 2'b00;

    apply_stimulus("reset", 1'b1, 1'b0, 8'h00, 1'b0, 2'b00);
    check_val("reset.dout0", 32'(dout), 32'h0);

    apply_stimulus("idle_shift", 1'b0, 1'b0, 8'hAA, 1'b1, 2'b11);
    check_val("idle_shift.dout", 32'(dout), 32'h0);

    apply_stimulus("load_b4", 1'b0, 1'b1, 8'hB4, 1'b0, 2'b01);
    check_val("load_b4.busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus("seq", 1'b0, 1'b0, 8'h00, 1'b1, 2'b01);
      check_val("seq.dout_const", 32'(dout), 32'(exp_seq[i]));
      check_val("seq.res_const",  32'(res),  32'(exp_res[i]));
    end
    check_val("seq.cnt4", 32'(cnt), 32'd4);
    check_val("seq.done", 32'(done), 32'h1);

    apply_stimulus("done_shift", 1'b0, 1'b0, 8'h00, 1'b1, 2'b11);
    check_val("done_shift.dout", 32'(dout), 32'h55);
    check_val("done_shift.res",  32'(res),  32'h2);

    apply_stimulus("load_dn_0f", 1'b0, 1'b1, 8'h0F, 1'b0, 2'b00);
    check_val("load_dn_0f.dout", 32'(dout), 32'h0F);
    check_val("load_dn_0f.done", 32'(done), 32'h0);

    apply_stimulus("load_shift_ff", 1'b0, 1'b1, 8'hFF, 1'b1, 2'b10);
    check_val("load_shift_ff.dout", 32'(dout), 32'hFF);
    check_val("load_shift_ff.cnt",  32'(cnt),  32'h0);

    apply_stimulus("step1", 1'b0, 1'b0, 8'h00, 1'b1, 2'b00);
    apply_stimulus("step2", 1'b0, 1'b0, 8'h00, 1'b1, 2'b00);
    apply_stimulus("mid_rst", 1'b1, 1'b1, 8'h33, 1'b1, 2'b11);
    check_val("mid_rst.busy", 32'(busy), 32'h0);
    check_val("mid_rst.dout", 32'(dout), 32'h0);

    apply_stimulus("reload", 1'b0, 1'b1, 8'hC3, 1'b0, 2'b00);
    apply_stimulus("abort_step", 1'b0, 1'b0, 8'h00, 1'b1, 2'b11);
    apply_stimulus("abort_load", 1'b0, 1'b1, 8'h5A, 1'b0, 2'b00);
    check_val("abort_load.cnt", 32'(cnt), 32'h0);

    // Random traffic: mostly shifts, occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus("rand",
                     ($urandom_range(0, 31) == 0),
                     ($urandom_range(0, 5) == 0),
                     WIDTH'($urandom),
                     1'($urandom),
                     2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
